sdram_burst_scheduler: RTL
==========================

Name: sdram_burst_scheduler

Overview:
- Round-robin scheduler that shares one SDRAM burst engine between four FIFO ports: port 0 = RD1, 1 = RD2, 2 = WR1, 3 = WR2.
- Decides which port is eligible and selects the next one.
- Owns each port's running address with wrap-around.
- Issues one burst command at a time and waits for the engine's done pulse.
- Sits between the port FIFOs' used-word counters and the burst/command sequencer.

Parameters:
ASIZE, 23, SDRAM word address width
LSIZE, 9, burst length width
USIZE, 16, FIFO used-word count width

Ports:
CLK  in  1  system clock, all logic on rising edge
RESET  in  1  asynchronous, active-high reset
RD_USED  in  2*USIZE  read-FIFO write-side used words; port0 = [USIZE-1:0], port1 = upper
WR_USED  in  2*USIZE  write-FIFO read-side used words; port2 = [USIZE-1:0], port3 = upper
LEN  in  4*LSIZE  per-port burst length; port n = [n*LSIZE +: LSIZE]
BASE_ADDR  in  4*ASIZE  per-port start address
MAX_ADDR  in  4*ASIZE  per-port max address
LOAD  in  4  per-port address reload / port disable while high
BURST_DONE  in  1  one-cycle pulse from engine, burst complete
BURST_START  out  1  one-cycle command pulse
BURST_RD  out  1  1 = read burst, 0 = write burst; valid while BUSY
BURST_ADDR  out  ASIZE  burst start address; valid while BUSY
BURST_LEN  out  LSIZE  burst length; valid while BUSY
GRANT  out  4  one-hot granted port; 0 when idle
BUSY  out  1  burst outstanding

Behaviour:
- Reset (async, RESET=1), immediate regardless of state:
  - All outputs 0; FSM to IDLE; RR pointer = 0.
  - Running address rADDR[n] = BASE_ADDR[n] (sampled during reset).
- Eligibility, combinational per port; all terms require LEN[n] != 0 and LOAD[n] = 0:
  - Read port: RD_USED < LEN.
  - Write port: WR_USED >= LEN.
- FSM states IDLE, ARB, ISSUE, WAIT:
  - IDLE: if any port is eligible -> ARB.
  - ARB: pick the first eligible port searching PTR, PTR+1, ... mod 4. Latch GRANT, BURST_RD, BURST_ADDR = rADDR[n], BURST_LEN = LEN[n]; BUSY = 1 -> ISSUE. If no port is eligible any more -> IDLE with nothing latched.
  - ISSUE: BURST_START = 1 for exactly this cycle -> WAIT.
  - WAIT: on BURST_DONE -> IDLE. GRANT, BUSY and the burst fields drop to 0 on the next edge. PTR = granted index + 1 mod 4.
- Latency: port eligible in IDLE cycle t -> BURST_START high in cycle t+2. Minimum spacing between BURST_START pulses = 4 cycles (done-to-start = 3).
- Address update on BURST_DONE for the granted port n, computed at ASIZE+1 bits (no underflow):
  - If rADDR + LEN < MAX_ADDR: rADDR <= rADDR + LEN.
  - Otherwise rADDR <= BASE_ADDR (wrap).
  - If MAX_ADDR < LEN: always wrap.
- LOAD[n] = 1 any cycle: rADDR[n] <= BASE_ADDR[n].
  - LOAD wins over a simultaneous done update for that port.
  - An outstanding burst on that port continues with its latched address; its done-time update is discarded.
- BURST_DONE outside WAIT: ignored.
- BURST_DONE coincident with BURST_START: ignored, logged by assertion.
- Burst fields are stable from ARB exit until BUSY falls; input changes do not affect them.

Optional Feature:
- Macro READ_PRIORITY_EN.
- Defined: ARB first searches eligible read ports (0, 1) in round-robin order, and considers write ports (2, 3) only when no read port is eligible. Separate read and write pointers; each advances only on a grant in its own class.
- Undefined: pure 4-way round robin with a single pointer.

Test Plan:
- Reset: RESET=1 mid-WAIT -> GRANT, BUSY, BURST_START = 0 in the same cycle; after release, the first grant goes to port 0 when all ports are eligible.
- Fairness: all four ports permanently eligible, LEN=8, BURST_DONE 5 cycles after each start -> GRANT sequence 0001, 0010, 0100, 1000, 0001; start-to-start = 8 cycles. With READ_PRIORITY_EN: 0001, 0010, 0001, ...
- Wrap: port 2 BASE=0x100, MAX=0x120, LEN=0x10 -> BURST_ADDR 0x100, 0x110, 0x100.
- Eligibility edges: WR_USED=7 with LEN=8 -> no grant; raise to 8 -> BURST_START 2 cycles later. LEN=0 -> never granted.
- LOAD during burst: port 0 rADDR=0x40, BASE=0x0; LOAD pulse in WAIT, then DONE -> next port-0 BURST_ADDR = 0x0. LOAD held high -> port never granted.
- Spurious done: BURST_DONE pulse in IDLE -> no state change, no address change.

Source files
------------

// File: rtl/sdram_burst_scheduler.sv
// Round-robin burst scheduler: four FIFO ports share one SDRAM burst engine.
// Optional READ_PRIORITY_EN: reads win over writes, with separate RR pointers.
module sdram_burst_scheduler #(
    parameter int ASIZE = 23,
    parameter int LSIZE = 9,
    parameter int USIZE = 16
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [2*USIZE-1:0] RD_USED,
    input  logic [2*USIZE-1:0] WR_USED,
    input  logic [4*LSIZE-1:0] LEN,
    input  logic [4*ASIZE-1:0] BASE_ADDR,
    input  logic [4*ASIZE-1:0] MAX_ADDR,
    input  logic [3:0]         LOAD,
    input  logic               BURST_DONE,
    output logic               BURST_START,
    output logic               BURST_RD,
    output logic [ASIZE-1:0]   BURST_ADDR,
    output logic [LSIZE-1:0]   BURST_LEN,
    output logic [3:0]         GRANT,
    output logic               BUSY
);

    typedef enum logic [1:0] {S_IDLE, S_ARB, S_ISSUE, S_WAIT} state_t;

    state_t           state_q, state_d;
    logic [USIZE-1:0] used_a [4];
    logic [LSIZE-1:0] len_a  [4];
    logic [ASIZE-1:0] base_a [4];
    logic [ASIZE-1:0] max_a  [4];
    logic [ASIZE-1:0] raddr  [4];
    logic [3:0]       lt;
    logic [3:0]       elig;
    logic [1:0]       sel, idx, gidx;
    logic             found, done_ok, load_hit;
    logic [ASIZE:0]   sum;
`ifdef READ_PRIORITY_EN
    logic             rptr, wptr;
`else
    logic [1:0]       ptr;
`endif

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            used_a[n] = (n < 2) ? RD_USED[(n%2)*USIZE +: USIZE]
                                : WR_USED[(n%2)*USIZE +: USIZE];
            len_a[n]  = LEN[n*LSIZE +: LSIZE];
            base_a[n] = BASE_ADDR[n*ASIZE +: ASIZE];
            max_a[n]  = MAX_ADDR[n*ASIZE +: ASIZE];
            lt[n]     = {{LSIZE{1'b0}}, used_a[n]} < {{USIZE{1'b0}}, len_a[n]};
            elig[n]   = ((n < 2) ? lt[n] : !lt[n])
                        && (len_a[n] != '0) && !LOAD[n];
        end
    end

    always_comb begin
        sel   = '0;
        idx   = '0;
        found = 1'b0;
`ifdef READ_PRIORITY_EN
        for (int k = 0; k < 2; k++) begin
            idx = {1'b0, rptr ^ 1'(k)};
            if (!found && elig[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        for (int k = 0; k < 2; k++) begin
            idx = {1'b1, wptr ^ 1'(k)};
            if (!found && elig[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
`else
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && elig[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (|elig) state_d = S_ARB;
            S_ARB:   state_d = found ? S_ISSUE : S_IDLE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (BURST_DONE) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign BURST_START = (state_q == S_ISSUE);
    assign done_ok     = (state_q == S_WAIT) && BURST_DONE;
    // Sum kept one bit wider so a wrap is detected instead of overflowing.
    assign sum = {1'b0, raddr[gidx]}
               + {{(ASIZE+1-LSIZE){1'b0}}, BURST_LEN};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            GRANT      <= '0;
            gidx       <= '0;
            BURST_RD   <= 1'b0;
            BURST_ADDR <= '0;
            BURST_LEN  <= '0;
            BUSY       <= 1'b0;
            load_hit   <= 1'b0;
`ifdef READ_PRIORITY_EN
            rptr       <= 1'b0;
            wptr       <= 1'b0;
`else
            ptr        <= '0;
`endif
            for (int n = 0; n < 4; n++) raddr[n] <= base_a[n];
        end else begin
            state_q <= state_d;
            if (state_q == S_ARB && found) begin
                GRANT      <= 4'(1) << sel;
                gidx       <= sel;
                BURST_RD   <= ~sel[1];
                BURST_ADDR <= raddr[sel];
                BURST_LEN  <= len_a[sel];
                BUSY       <= 1'b1;
                load_hit   <= 1'b0;
            end
            // A reload under an outstanding burst voids its address update.
            if (BUSY && LOAD[gidx]) load_hit <= 1'b1;
            if (done_ok) begin
                GRANT      <= '0;
                BURST_RD   <= 1'b0;
                BURST_ADDR <= '0;
                BURST_LEN  <= '0;
                BUSY       <= 1'b0;
                load_hit   <= 1'b0;
`ifdef READ_PRIORITY_EN
                if (!gidx[1]) rptr <= ~gidx[0];
                else          wptr <= ~gidx[0];
`else
                ptr <= gidx + 2'd1;
`endif
            end
            for (int n = 0; n < 4; n++) begin
                if (LOAD[n]) begin
                    raddr[n] <= base_a[n];
                end else if (done_ok && gidx == 2'(n) && !load_hit) begin
                    if (sum < {1'b0, max_a[n]}) raddr[n] <= sum[ASIZE-1:0];
                    else                        raddr[n] <= base_a[n];
                end
            end
        end
    end

    a_done_vs_start: assert property (@(posedge CLK) disable iff (RESET)
        !(BURST_START && BURST_DONE));

endmodule
